csdf_rr_acc: RTL and testbench

Multi-flux cyclo-static accumulating actor, the parametrised successor of the single-priority CSDF adder actor. Each of `FLUX` independent fluxes consumes one token from each of its `PORTS` input FIFOs per firing and accumulates their sum. After `NUM_OP` firings it emits one tagged result token to the shared output FIFO. Fluxes are served by a round-robin arbiter rather than fixed priority. A per-flux pending-result hold lets a flux whose output is blocked stall without stalling the other fluxes.

---
 rtl/csdf_rr_acc_if.sv | 24 ++
 rtl/csdf_rr_acc.sv | 142 ++++++++++++++
 tb/tb_csdf_rr_acc.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/csdf_rr_acc_if.sv
// FIFO-side bundles for csdf_rr_acc: a multi-slot read bundle and a single write bundle.
// The actor modports are what the accumulating actor sees; the fifo modports are the far side.
interface read_interface #(
  parameter int WIDTH = 9,
  parameter int N     = 4
);
  logic [WIDTH*N-1:0] dout;
  logic [N-1:0]       empty;
  logic [N-1:0]       read;

  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] din;
  logic             write;
  logic             full;

  modport actor (output din, output write, input full);
  modport fifo  (input din, input write, output full);
endinterface

// File: rtl/csdf_rr_acc.sv
// Multi-flux cyclo-static accumulating actor with round-robin flux arbitration and a
// per-flux pending-result hold. Define CSDF_SAT_EN for saturating adds (default: wrap).
module csdf_rr_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int NUM_OP     = 4,
  parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input logic           clk,
  input logic           rst,
  read_interface.actor  read_port,
  write_interface.actor write_port
);
  localparam int CNT_W = (NUM_OP > 1) ? $clog2(NUM_OP) : 1;
  localparam logic [CNT_W-1:0]     CNT_INIT  = CNT_W'(NUM_OP - 1);
  localparam logic [TAG_WIDTH-1:0] LAST_INIT = TAG_WIDTH'(FLUX - 1);

  // Handshake: read/write are combinational strobes; a token moves in any cycle its strobe is 1.
  function automatic logic [DATA_WIDTH-1:0] add_dw(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
`ifdef CSDF_SAT_EN
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  logic [CNT_W-1:0]      cnt_q [FLUX];
  logic [CNT_W-1:0]      cnt_d [FLUX];
  logic [DATA_WIDTH-1:0] acc_q [FLUX];
  logic [DATA_WIDTH-1:0] acc_d [FLUX];
  logic [FLUX-1:0]       pend_q;
  logic [FLUX-1:0]       pend_d;
  logic [TAG_WIDTH-1:0]  last_q;
  logic [TAG_WIDTH-1:0]  last_d;

  logic [DATA_WIDTH-1:0] sum_w  [FLUX];
  logic [DATA_WIDTH-1:0] acc_nx [FLUX];
  logic [FLUX-1:0]       all_in;
  logic [FLUX-1:0]       elig;
  logic                  gnt_vld;
  int                    gnt_idx;
  logic [FLUX*PORTS*TAG_WIDTH-1:0] unused_tags;

  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      sum_w[f]  = '0;
      all_in[f] = 1'b1;
      for (int p = 0; p < PORTS; p++) begin
        sum_w[f]  = add_dw(sum_w[f], read_port.dout[(f*PORTS+p)*WIDTH +: DATA_WIDTH]);
        all_in[f] = all_in[f] & ~read_port.empty[f*PORTS+p];
      end
      acc_nx[f] = add_dw(acc_q[f], sum_w[f]);
      // A held result only competes when it can actually be written.
      elig[f]   = pend_q[f] ? ~write_port.full : all_in[f];
    end
  end

  always_comb begin
    for (int s = 0; s < FLUX*PORTS; s++) begin
      unused_tags[s*TAG_WIDTH +: TAG_WIDTH] = read_port.dout[s*WIDTH+DATA_WIDTH +: TAG_WIDTH];
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = 0;
    for (int i = 1; i <= FLUX; i++) begin
      idx = (int'(last_q) + i) % FLUX;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    read_port.read   = '0;
    write_port.write = 1'b0;
    write_port.din   = '0;
    last_d           = last_q;
    pend_d           = pend_q;
    for (int f = 0; f < FLUX; f++) begin
      cnt_d[f] = cnt_q[f];
      acc_d[f] = acc_q[f];
    end
    if (!rst && gnt_vld) begin
      last_d = TAG_WIDTH'(gnt_idx);
      for (int f = 0; f < FLUX; f++) begin
        if (f == gnt_idx) begin
          if (pend_q[f]) begin
            write_port.write = 1'b1;
            write_port.din   = {TAG_WIDTH'(f), acc_q[f]};
            cnt_d[f]         = CNT_INIT;
            acc_d[f]         = '0;
            pend_d[f]        = 1'b0;
          end else begin
            read_port.read[f*PORTS +: PORTS] = '1;
            if (cnt_q[f] == '0) begin
              if (!write_port.full) begin
                write_port.write = 1'b1;
                write_port.din   = {TAG_WIDTH'(f), acc_nx[f]};
                cnt_d[f]         = CNT_INIT;
                acc_d[f]         = '0;
              end else begin
                acc_d[f]  = acc_nx[f];
                pend_d[f] = 1'b1;
              end
            end else begin
              acc_d[f] = acc_nx[f];
              cnt_d[f] = cnt_q[f] - CNT_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        cnt_q[f] <= CNT_INIT;
        acc_q[f] <= '0;
      end
      pend_q <= '0;
      last_q <= LAST_INIT;
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        cnt_q[f] <= cnt_d[f];
        acc_q[f] <= acc_d[f];
      end
      pend_q <= pend_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_csdf_rr_acc.sv
// Testbench for csdf_rr_acc (FLUX=2, PORTS=2, NUM_OP=4, DATA_WIDTH=8): table vectors
// checked per cycle, written tokens checked against an expected queue.
module tb_csdf_rr_acc;
  localparam int DW = 8;
  localparam int FLUX = 2;
  localparam int PORTS = 2;
  localparam int NUM_OP = 4;
  localparam int W = 9;
  localparam int N = FLUX * PORTS;
`ifdef CSDF_SAT_EN
  localparam logic [W-1:0] BIG_RES = 9'h0FF;
`else
  localparam logic [W-1:0] BIG_RES = 9'h0B0;
`endif

  typedef struct {
    logic [N-1:0]    empty;
    logic [N*DW-1:0] d;
    logic            full;
    logic [N-1:0]    exp_read;
    logic            exp_write;
    logic [W-1:0]    exp_din;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  read_interface #(.WIDTH(W), .N(N)) rd_if ();
  write_interface #(.WIDTH(W)) wr_if ();

  csdf_rr_acc #(
    .DATA_WIDTH(DW), .FLUX(FLUX), .PORTS(PORTS), .NUM_OP(NUM_OP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_port(rd_if),
    .write_port(wr_if)
  );

  function automatic vec_t mk(input logic [N-1:0] e, input int d0, input int d1, input int d2,
                              input int d3, input logic fu, input logic [N-1:0] er,
                              input logic ew, input logic [W-1:0] ed);
    vec_t v;
    v.empty = e;
    v.d = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    v.full = fu;
    v.exp_read = er;
    v.exp_write = ew;
    v.exp_din = ed;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rd_if.empty = v.empty;
    wr_if.full = v.full;
    for (int s = 0; s < N; s++) begin
      rd_if.dout[s*W +: DW] = v.d[s*DW +: DW];
      rd_if.dout[s*W+DW] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    drive(v);
    if (v.exp_write) exp_q.push_back(v.exp_din);
    #3;
    check({nm, "_read"}, 32'(rd_if.read), 32'(v.exp_read));
    check({nm, "_write"}, 32'(wr_if.write), 32'(v.exp_write));
  endtask

  // Scoreboard: every written token must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_if.write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_write: got din %0h expected no write", wr_if.din);
      end else begin
        check("sb_din", 32'(wr_if.din), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_if.empty = '1;
    rd_if.dout = '0;
    wr_if.full = 1'b0;

    // flux 1 has one empty port; flux 0 runs alone: (1,2) x4 -> {0,12}
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0100, 1, 2, 9, 9, 0, 4'b0011, 0, '0));
    tbl.push_back(mk(4'b0100, 1, 2, 9, 9, 0, 4'b0011, 1, 9'h00C));
    // both fluxes full of data: grants alternate starting with flux 1
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(4'b0000, 1, 1, 3, 4, 0, 4'b1100, 0, '0));
      tbl.push_back(mk(4'b0000, 1, 1, 3, 4, 0, 4'b0011, 0, '0));
    end
    tbl.push_back(mk(4'b0000, 1, 1, 3, 4, 0, 4'b1100, 1, 9'h11C));
    tbl.push_back(mk(4'b0000, 1, 1, 3, 4, 0, 4'b0011, 1, 9'h008));
    // all empty: no grant
    tbl.push_back(mk(4'b1111, 1, 1, 3, 4, 0, 4'b0000, 0, '0));
    // (200,100) x4: wrap 176 or saturate 255
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0100, 200, 100, 0, 0, 0, 4'b0011, 0, '0));
    tbl.push_back(mk(4'b0100, 200, 100, 0, 0, 0, 4'b0011, 1, BIG_RES));
    // flux 0 final firing blocked by full, flux 1 keeps firing, then drain
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0100, 1, 2, 1, 1, 0, 4'b0011, 0, '0));
    tbl.push_back(mk(4'b0100, 1, 2, 1, 1, 1, 4'b0011, 0, '0));
    tbl.push_back(mk(4'b0100, 1, 2, 1, 1, 1, 4'b0000, 0, '0));
    tbl.push_back(mk(4'b0000, 1, 2, 1, 1, 1, 4'b1100, 0, '0));
    tbl.push_back(mk(4'b0000, 1, 2, 1, 1, 1, 4'b1100, 0, '0));
    tbl.push_back(mk(4'b0000, 1, 2, 1, 1, 0, 4'b0000, 1, 9'h00C));
    tbl.push_back(mk(4'b0000, 1, 2, 1, 1, 0, 4'b1100, 0, '0));
    tbl.push_back(mk(4'b0000, 1, 2, 1, 1, 0, 4'b0011, 0, '0));
    tbl.push_back(mk(4'b0000, 1, 2, 1, 1, 0, 4'b1100, 1, 9'h108));

    // reset state: outputs quiet while rst is high even with data available
    repeat (2) @(posedge clk);
    #1;
    drive(mk(4'b0000, 7, 7, 7, 7, 0, '0, 0, '0));
    #3;
    check("rst_read", 32'(rd_if.read), 32'h0);
    check("rst_write", 32'(wr_if.write), 32'h0);
    check("rst_din", 32'(wr_if.din), 32'h0);
    rd_if.empty = '1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // reset in the middle of an accumulation discards the partial state
    apply(mk(4'b0100, 5, 5, 0, 0, 0, 4'b0011, 0, '0), "mid0");
    apply(mk(4'b0100, 5, 5, 0, 0, 0, 4'b0011, 0, '0), "mid1");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(mk(4'b0000, 5, 5, 5, 5, 0, '0, 0, '0));
      #3;
      check($sformatf("mrst%0d_read", i), 32'(rd_if.read), 32'h0);
      check($sformatf("mrst%0d_write", i), 32'(wr_if.write), 32'h0);
      check($sformatf("mrst%0d_din", i), 32'(wr_if.din), 32'h0);
    end
    rd_if.empty = '1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply(mk(4'b0100, 1, 1, 0, 0, 0, 4'b0011, 0, '0), $sformatf("post%0d", i));
    apply(mk(4'b0100, 1, 1, 0, 0, 0, 4'b0011, 1, 9'h008), "post3");

    apply(mk(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 0, '0), "idle");
    @(posedge clk);
    #1;
    check("sb_outstanding", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
